// File: rtl/sar_adc_scan.sv
// Multi-channel successive-approximation ADC scan controller with optional
// oversampled averaging; drives an external mux, R-2R DAC and comparator.
module sar_adc_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SETTLE   = 3,
    parameter int AVG_LOG2 = 0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                ADC_Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Continuous,
    input  logic [CHANNELS-1:0] ChanMask,
    input  logic                CompIn,
    output logic [WIDTH-1:0]    DacOut,
    output logic [CH_W-1:0]     ChanSel,
    output logic                Busy,
    output logic                Valid,
    output logic [WIDTH-1:0]    Result,
    output logic [CH_W-1:0]     ResultChan
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int SET_W = $clog2(SETTLE);
    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam logic [SMP_W-1:0] N_SAMP   = SMP_W'(1 << AVG_LOG2);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_BIT,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t              state_reg, state_next;
    logic                comp_meta_reg, comp_s_reg;
    logic [SET_W-1:0]    settle_reg, settle_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [WIDTH-1:0]    code_reg, code_next;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic [SMP_W-1:0]    samples_reg, samples_next;
    logic [CHANNELS-1:0] mask_reg, mask_next;
    logic [CH_W-1:0]     chan_reg, chan_next;
    logic [WIDTH-1:0]    result_reg, result_next;
    logic [CH_W-1:0]     result_chan_reg, result_chan_next;
    logic                valid_reg, valid_next;

    logic [WIDTH-1:0]    trial_bit;
    logic [ACC_W-1:0]    acc_sum;
    logic [SMP_W-1:0]    samples_inc;
    logic [CHANNELS-1:0] above_mask;

    // Lowest-numbered set bit; scans downward so the lowest match wins.
    function automatic logic [CH_W-1:0] lowest_set(input logic [CHANNELS-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = CH_W'(i);
            end
        end
        return r;
    endfunction

    // Enabled channels strictly above the one currently selected.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_above
            assign above_mask[gi] = mask_reg[gi] && (gi > int'(chan_reg));
        end
    endgenerate

    assign trial_bit   = WIDTH'(1) << idx_reg;
    assign acc_sum     = acc_reg + ACC_W'(code_reg);
    assign samples_inc = samples_reg + 1'b1;

    always_ff @(posedge ADC_Clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= S_IDLE;
            comp_meta_reg   <= 1'b0;
            comp_s_reg      <= 1'b0;
            settle_reg      <= '0;
            idx_reg         <= '0;
            code_reg        <= '0;
            acc_reg         <= '0;
            samples_reg     <= '0;
            mask_reg        <= '0;
            chan_reg        <= '0;
            result_reg      <= '0;
            result_chan_reg <= '0;
            valid_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            comp_meta_reg   <= CompIn;
            comp_s_reg      <= comp_meta_reg;
            settle_reg      <= settle_next;
            idx_reg         <= idx_next;
            code_reg        <= code_next;
            acc_reg         <= acc_next;
            samples_reg     <= samples_next;
            mask_reg        <= mask_next;
            chan_reg        <= chan_next;
            result_reg      <= result_next;
            result_chan_reg <= result_chan_next;
            valid_reg       <= valid_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        settle_next      = settle_reg;
        idx_next         = idx_reg;
        code_next        = code_reg;
        acc_next         = acc_reg;
        samples_next     = samples_reg;
        mask_next        = mask_reg;
        chan_next        = chan_reg;
        result_next      = result_reg;
        result_chan_next = result_chan_reg;
        valid_next       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (Start && (|ChanMask)) begin
                    mask_next   = ChanMask;
                    chan_next   = lowest_set(ChanMask);
                    settle_next = '0;
                    state_next  = S_SELECT;
                end
            end

            S_SELECT: begin
                if (settle_reg == SET_LAST) begin
                    settle_next  = '0;
                    acc_next     = '0;
                    samples_next = '0;
                    code_next    = '0;
                    idx_next     = IDX_MSB;
                    state_next   = S_BIT;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end

            S_BIT: begin
                if (settle_reg == SET_LAST) begin
                    settle_next = '0;
                    code_next   = comp_s_reg ? (code_reg | trial_bit) : code_reg;
                    if (idx_reg == '0) begin
                        state_next = S_ACCUM;
                    end else begin
                        idx_next = idx_reg - 1'b1;
                    end
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end

            S_ACCUM: begin
                acc_next     = acc_sum;
                samples_next = samples_inc;
                code_next    = '0;
                if (samples_inc < N_SAMP) begin
                    idx_next   = IDX_MSB;
                    state_next = S_BIT;
                end else begin
                    // Result is loaded on entry so it is already new while Valid is high.
                    result_next      = WIDTH'(acc_sum >> AVG_LOG2);
                    result_chan_next = chan_reg;
                    valid_next       = 1'b1;
                    state_next       = S_OUTPUT;
                end
            end

            S_OUTPUT: begin
                if (|above_mask) begin
                    chan_next  = lowest_set(above_mask);
                    state_next = S_SELECT;
                end else if (Continuous && (|ChanMask)) begin
                    mask_next  = ChanMask;
                    chan_next  = lowest_set(ChanMask);
                    state_next = S_SELECT;
                end else begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign DacOut     = (state_reg == S_BIT) ? (code_reg | trial_bit) : '0;
    assign ChanSel    = chan_reg;
    assign Busy       = (state_reg != S_IDLE);
    assign Valid      = valid_reg;
    assign Result     = result_reg;
    assign ResultChan = result_chan_reg;

endmodule

// File: tb/tb_sar_adc_scan.sv
// Scoreboard bench for sar_adc_scan: ideal comparator models, expected results
// queued at Start, checked by per-DUT monitors on each Valid.
module tb_sar_adc_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int res;
        int cyc;
    } exp_t;

    logic       Reset, Start, Continuous, Start2, Continuous2;
    logic [3:0] ChanMask, ChanMask2;
    logic       CompIn, CompIn2;
    wire  [7:0] DacOut, Result, DacOut2, Result2;
    wire  [1:0] ChanSel, ResultChan, ChanSel2, ResultChan2;
    wire        Busy, Valid, Busy2, Valid2;

    sar_adc_scan #(.WIDTH(8), .CHANNELS(4), .SETTLE(3), .AVG_LOG2(0)) dut (
        .ADC_Clk(clk), .Reset(Reset), .Start(Start), .Continuous(Continuous),
        .ChanMask(ChanMask), .CompIn(CompIn), .DacOut(DacOut), .ChanSel(ChanSel),
        .Busy(Busy), .Valid(Valid), .Result(Result), .ResultChan(ResultChan)
    );

    sar_adc_scan #(.WIDTH(8), .CHANNELS(4), .SETTLE(3), .AVG_LOG2(2)) dut2 (
        .ADC_Clk(clk), .Reset(Reset), .Start(Start2), .Continuous(Continuous2),
        .ChanMask(ChanMask2), .CompIn(CompIn2), .DacOut(DacOut2), .ChanSel(ChanSel2),
        .Busy(Busy2), .Valid(Valid2), .Result(Result2), .ResultChan(ResultChan2)
    );

    // Analog world: per-channel input voltages and an ideal comparator.
    logic [7:0] vin[4];
    logic [7:0] vin2[4];
    int         conv2 = 0;
    int         base2 = 0;
    logic [7:0] dac2_prev = 8'h00;
    wire  [1:0] sel2 = 2'(conv2 - base2);

    assign CompIn  = (vin[ChanSel] >= DacOut);
    assign CompIn2 = (vin2[sel2] >= DacOut2);

    // A conversion on dut2 ends when the DAC returns to zero after a trial.
    always @(posedge clk) begin
        dac2_prev <= DacOut2;
        if (dac2_prev != 8'h00 && DacOut2 == 8'h00) conv2 <= conv2 + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   exp_end;
    logic watch_sel = 1'b0;
    int   sel_viol = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!Reset && Valid) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_valid", 1, 0);
            end else begin
                e = q1.pop_front();
                $display("txn dut1 chan=%0d result=%02h cyc=%0d", ResultChan, Result, cyc);
                check("dut1_result", Result, e.res);
                check("dut1_chan", ResultChan, e.chan);
                check("dut1_valid_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (!Reset && Valid2) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_valid", 1, 0);
            end else begin
                e = q2.pop_front();
                $display("txn dut2 chan=%0d result=%02h cyc=%0d", ResultChan2, Result2, cyc);
                check("dut2_result", Result2, e.res);
                check("dut2_chan", ResultChan2, e.chan);
                check("dut2_valid_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (watch_sel && Busy && (ChanSel == 2'd0 || ChanSel == 2'd2)) sel_viol <= sel_viol + 1;
    end

    // Called at a negedge; expects each enabled channel 29 cycles apart, lowest first.
    task automatic start_scan(input logic [3:0] m);
        int e;
        int k;
        exp_t x;
        ChanMask = m;
        Start    = 1'b1;
        e = cyc + 1;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                x.chan = i;
                x.res  = int'(vin[i]);
                x.cyc  = e + 28 + 29 * k;
                q1.push_back(x);
                exp_end = x.cyc;
                k++;
            end
        end
        @(negedge clk);
        Start = 1'b0;
        check("busy_after_start", Busy, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall_cycle", cyc, exp_end + 1);
        check("queue_drained", q1.size(), 0);
    endtask

    task automatic run2(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        int e;
        int n;
        exp_t x;
        vin2[0] = a; vin2[1] = b; vin2[2] = c; vin2[3] = d;
        base2  = conv2;
        Start2 = 1'b1;
        e = cyc + 1;
        x.chan = 0;
        x.res  = (int'(a) + int'(b) + int'(c) + int'(d)) / 4;
        x.cyc  = e + 103;
        q2.push_back(x);
        @(negedge clk);
        Start2 = 1'b0;
        check("busy2_after_start", Busy2, 1);
        n = 0;
        while (Busy2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("busy2_fall_cycle", cyc, e + 104);
        check("queue2_drained", q2.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        Reset = 1'b1; Start = 1'b0; Continuous = 1'b0; ChanMask = 4'b0000;
        Start2 = 1'b0; Continuous2 = 1'b0; ChanMask2 = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            vin[i] = 8'h00;
            vin2[i] = 8'h00;
        end
        #22;
        check("rst_dacout", DacOut, 0);
        check("rst_chansel", ChanSel, 0);
        check("rst_busy", Busy, 0);
        check("rst_valid", Valid, 0);
        check("rst_result", Result, 0);
        check("rst_resultchan", ResultChan, 0);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);

        // Single channel: typical value and both code boundaries.
        vin[0] = 8'h5A; start_scan(4'b0001); wait_idle();
        vin[0] = 8'h00; start_scan(4'b0001); wait_idle();
        vin[0] = 8'hFF; start_scan(4'b0001); wait_idle();

        // Sparse mask: channels 0 and 2 must never be selected.
        vin[0] = 8'h77; vin[1] = 8'h11; vin[2] = 8'h99; vin[3] = 8'hC3;
        @(negedge clk);
        watch_sel = 1'b1;
        start_scan(4'b1010);
        wait_idle();
        watch_sel = 1'b0;
        check("chansel_skips_disabled", sel_viol, 0);

        // Empty mask is refused.
        ChanMask = 4'b0000; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("mask0_busy_now", Busy, 0);
        repeat (3) @(negedge clk);
        check("mask0_busy_later", Busy, 0);

        // Continuous mode: three conversions, stray Start ignored, drop mid-third.
        vin[0] = 8'h80;
        Continuous = 1'b1;
        start_scan(4'b0001);
        base = exp_end;
        q1.push_back('{0, 8'h80, base + 29});
        q1.push_back('{0, 8'h80, base + 58});
        exp_end = base + 58;
        repeat (10) @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        while (cyc < base + 44) @(negedge clk);
        check("cont_busy_held", Busy, 1);
        Continuous = 1'b0;
        wait_idle();

        // Randomised masks and voltages, each started the cycle Busy falls.
        @(negedge clk);
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) vin[i] = 8'($urandom_range(0, 255));
            start_scan(4'($urandom_range(1, 15)));
            wait_idle();
        end

        // Asynchronous reset in the middle of a bit trial.
        vin[0] = 8'h33;
        start_scan(4'b0001);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        Reset = 1'b1;
        #1;
        q1.delete();
        check("midrst_dacout", DacOut, 0);
        check("midrst_chansel", ChanSel, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_valid", Valid, 0);
        check("midrst_result", Result, 0);
        check("midrst_resultchan", ResultChan, 0);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        vin[0] = 8'hA5; start_scan(4'b0001); wait_idle();

        // Averaging instance: alternating 0x40/0x43 then random sets.
        run2(8'h40, 8'h43, 8'h40, 8'h43);
        for (int it = 0; it < 3; it++) begin
            run2(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        check("final_q1_empty", q1.size(), 0);
        check("final_q2_empty", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sar_adc_scan.md
# sar_adc_scan

Parametrised successive-approximation ADC controller that scans a masked set of analog channels through an external multiplexer, comparator and R-2R DAC, with optional oversampled averaging. It is the successor to the fixed 8-bit single-channel SAR converter. It sits between the GPIO comparator/DAC pins and the consumers (hex display, UART streamer), delivering one tagged result per enabled channel per scan.

## Interface
- WIDTH, 8: conversion resolution in bits (4..16).
- CHANNELS, 4: number of mux channels (1..16); CH_W = max(1, clog2(CHANNELS)).
- SETTLE, 3: cycles per bit trial and per mux settle (>= 3, covers the 2-flop synchroniser).
- AVG_LOG2, 0: log2 of conversions averaged per channel (0..4).

Ports:
- ADC_Clk  in  1  conversion clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request to begin a scan; ignored while Busy or when ChanMask == 0.
- Continuous  in  1  when high at end of scan, restart immediately.
- ChanMask  in  CHANNELS  enabled channels; captured on accepted Start and on each continuous restart.
- CompIn  in  1  asynchronous comparator output; 1 means Vin >= DAC.
- DacOut  out  WIDTH  DAC trial code.
- ChanSel  out  CH_W  analog mux select.
- Busy  out  1  high from the cycle after an accepted Start until the scan ends.
- Valid  out  1  one-cycle pulse when Result/ResultChan are new.
- Result  out  WIDTH  averaged conversion result.
- ResultChan  out  CH_W  channel number of Result.

## Operation
- CompIn passes through a 2-flop synchroniser (comp_s) before any use.
- States: IDLE, SELECT, BIT, ACCUM, OUTPUT.
- IDLE: Busy=0. Accepted Start latches the mask into mask_r, sets ChanSel to the lowest set bit, clears DacOut, and goes to SELECT.
- SELECT: hold for SETTLE cycles for mux settling; clear the accumulator and sample count; go to BIT with bit index = WIDTH-1.
- BIT: DacOut = committed bits | (1 << idx). Hold for SETTLE cycles. On the last cycle, sample comp_s: 1 keeps the bit, 0 clears it. Decrement idx; after idx 0 is resolved, go to ACCUM.
- ACCUM (1 cycle): acc += code. acc is WIDTH+AVG_LOG2 bits and cannot overflow. Clear DacOut. If samples < 2^AVG_LOG2, return to BIT at idx WIDTH-1; otherwise go to OUTPUT.
- OUTPUT (1 cycle): Result <= acc >> AVG_LOG2 (truncating), ResultChan <= ChanSel, Valid=1.
  - If a higher set bit remains in mask_r: ChanSel moves to it, go to SELECT.
  - Else if Continuous: re-capture ChanMask. Nonzero: ChanSel = lowest set bit, go to SELECT. Zero: go to IDLE.
  - Else go to IDLE.
- Start while Busy: ignored. ChanMask changes mid-scan: no effect until the next capture.
- Reset at any point: immediately IDLE, with all state and outputs cleared.

## Timing
- Reset values: DacOut=0, ChanSel=0, Busy=0, Valid=0, Result=0, ResultChan=0, synchroniser flops=0.
- Start sampled at cycle T; Busy=1 and state=SELECT from T+1.
- Per channel: SETTLE + 2^AVG_LOG2 × (WIDTH×SETTLE + 1) + 1 cycles.
  - Default parameters: 3 + 25 + 1 = 29 cycles.
  - Valid asserted in the last of these cycles.
- Result/ResultChan update in the cycle Valid is high and hold until the next Valid.
- Between channels within a scan, no extra idle cycle: OUTPUT is followed directly by SELECT.
- Busy falls in the cycle after the final OUTPUT. A new Start is accepted in that same cycle.
- Comparator must be stable ≤ SETTLE-2 cycles after a DacOut change (synchroniser plus sample edge).

## Test plan
- Comparator model CompIn = (Vin >= DacOut), with WIDTH=8, SETTLE=3, AVG_LOG2=0, ChanMask=4'b0001:
  - Vin=0x5A: Valid 29 cycles after Start, Result=0x5A, ResultChan=0.
  - Vin=0x00 and Vin=0xFF: Result=0x00 and 0xFF (all-zero and all-one boundaries).
- ChanMask=4'b1010, Vin per channel {ch1=0x11, ch3=0xC3}: two Valid pulses 29 cycles apart, (1, 0x11) then (3, 0xC3); Busy then falls; ChanSel never equals 0 or 2.
- AVG_LOG2=2, ch0 Vin alternating 0x40/0x43 per conversion: sum 0x106, Result=0x41. Valid at 3+4×25+1 = 104 cycles.
- Continuous=1, ChanMask=4'b0001, Vin=0x80: Valid every 29 cycles with Busy held high. Drop Continuous mid-conversion: that conversion completes, then Busy falls. Start pulses during the scan are ignored.
- Edge cases:
  - Reset asserted mid-BIT: all outputs 0 immediately.
  - Start with ChanMask=0: Busy stays 0.
  - Start in the cycle Busy falls: accepted.
